wr_ptr_handler: RTL
===================

WR_PTR_HANDLER -- requirements
Module: wr_ptr_handler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, giving memory address bits (depth = 2^ADDR_WIDTH); legal values are 2 or more.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, giving the number of flops synchronising the read pointer; legal values are 2 or more.
REQ-003 SHALL have parameter AFULL_TH, default 2, giving free slots remaining at or below which almost_full asserts.
REQ-004 wr_clk  input  1  write-domain clock; the only clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 wr_en  input  1  write request from producer.
REQ-007 rd_ptr_gray_async  input  ADDR_WIDTH+1  Gray read pointer from read domain, asynchronous to wr_clk.
REQ-008 wr_fire  output  1  memory write strobe, = wr_en & ~full (combinational).
REQ-009 wr_addr  output  ADDR_WIDTH  memory write address, = wr_ptr_bin[ADDR_WIDTH-1:0].
REQ-010 wr_ptr_bin  output  ADDR_WIDTH+1  registered binary write pointer with wrap MSB.
REQ-011 wr_ptr_gray  output  ADDR_WIDTH+1  registered Gray write pointer, sent to read domain.
REQ-012 full  output  1  registered; FIFO full as seen from write domain.
REQ-013 almost_full  output  1  registered; free slots <= AFULL_TH.
REQ-014 wr_count  output  ADDR_WIDTH+1  registered fill level, pessimistic estimate.
REQ-015 overflow  output  1  sticky error flag: write attempted while full.

Function
REQ-016 A write SHALL be accepted only when wr_en=1 and full=0; wr_en while full SHALL NOT change any pointer.
REQ-017 On accept, wr_ptr_bin SHALL increment by 1 modulo 2^(ADDR_WIDTH+1) at the same edge; otherwise it holds.
REQ-018 wr_ptr_gray SHALL be a flop loaded with gray(wr_ptr_bin_next) = next ^ (next>>1), so it always equals gray(wr_ptr_bin) and is glitch-free.
REQ-019 rd_ptr_gray_async SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (rd_gray_sync) is used.
REQ-020 rd_gray_sync SHALL be converted Gray-to-binary (rd_bin_sync) by prefix XOR from the MSB.
REQ-021 full SHALL load (gray(wr_ptr_bin_next) == {~rd_gray_sync[AW:AW-1], rd_gray_sync[AW-2:0]}) every edge.
REQ-022 wr_count SHALL load (wr_ptr_bin_next - rd_bin_sync) modulo 2^(ADDR_WIDTH+1); range 0..2^ADDR_WIDTH.
REQ-023 almost_full SHALL load (count_next >= 2^ADDR_WIDTH - AFULL_TH); full implies almost_full.
REQ-024 overflow SHALL set on any edge where wr_en=1 and full=1, and clear only on rst.
REQ-025 After a read-side release, full SHALL deassert no later than SYNC_STAGES+1 wr_clk edges after rd_ptr_gray_async changes; it SHALL never deassert early (pessimistic).
REQ-026 Wrap-around SHALL be seamless: pointer 2^(ADDR_WIDTH+1)-1 SHALL advance to 0, with wr_addr wrapping at 2^ADDR_WIDTH.

Reset
REQ-027 While rst=1 at an edge, wr_ptr_bin, wr_ptr_gray, the sync chain, wr_count, full, almost_full and overflow SHALL all load 0; wr_en SHALL be ignored.
REQ-028 wr_fire SHALL be 1 during rst if wr_en=1 and full=0; the consumer SHALL gate the memory write with its own reset.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight write and the pointers SHALL restart at 0.

Structure
REQ-030 The shared async_fifo definitions header SHALL hold the ADDR_WIDTH default and the bin-to-gray and gray-to-bin functions; the read-side handler reuses them.
REQ-031 The synchroniser SHALL be a separate sub-module, sync_gray_ff (parameters WIDTH, STAGES), reused by the read side.
REQ-032 No latches and no combinational path from rd_ptr_gray_async to any output.

Verification (ADDR_WIDTH=4, SYNC_STAGES=2, AFULL_TH=2)
REQ-033 Reset, rd_ptr_gray_async=0, 16 consecutive writes -> full=1 at the 16th accept edge, wr_ptr_bin=5'b10000, wr_ptr_gray=5'b11000, wr_count=16.
REQ-034 Write attempt with full=1 -> wr_fire=0, pointers unchanged, overflow=1 next edge and held until rst.
REQ-035 While full, drive rd_ptr_gray_async=5'b00110 (binary 4) -> full=0 and wr_count=12 by the 3rd edge, not before the 2nd.
REQ-036 Fill to 13, then 1 more write -> almost_full=1 with wr_count=14, and full stays 0.
REQ-037 Read pointer tracks writes (lag 1), 40 writes -> wr_ptr_bin=8, wr_addr=8, wr_ptr_gray=5'b01100, full never 1.
REQ-038 rst=1 with wr_en=1 at wr_count=7 -> every registered output is 0 on the next edge.

Source files
------------

// File: rtl/wr_ptr_handler_pkg.sv
// Definitions shared by the async FIFO pointer handlers: default address width
// and the Gray-code conversions used on both the write and read sides.
package wr_ptr_handler_pkg;

  localparam int ADDR_WIDTH_DEF = 4;

  // Operands are zero-extended to 32 bits; callers keep only the low bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/wr_ptr_handler_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module sync_gray_ff #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_d;
  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_handler.sv
// Write-side pointer handler of an async FIFO: binary/Gray write pointers,
// synchronised read pointer, and pessimistic full/almost_full/fill level.
module wr_ptr_handler
  import wr_ptr_handler_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int AFULL_TH    = 2
) (
  input  logic                  wr_clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rd_ptr_gray_async,
  output logic                  wr_fire,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [ADDR_WIDTH:0]   wr_ptr_bin,
  output logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH     = PW'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = DEPTH - PW'(AFULL_TH);

  logic [ADDR_WIDTH:0] rd_gray_sync;
  logic [ADDR_WIDTH:0] rd_bin_sync;
  logic [ADDR_WIDTH:0] wr_ptr_bin_d,  wr_ptr_bin_q;
  logic [ADDR_WIDTH:0] wr_ptr_gray_d, wr_ptr_gray_q;
  logic [ADDR_WIDTH:0] wr_count_d,    wr_count_q;
  logic                full_d,        full_q;
  logic                almost_full_d, almost_full_q;
  logic                overflow_d,    overflow_q;
  logic                fire;
  logic [31:0]         gray_tmp;
  logic [31:0]         bin_tmp;
  logic                unused_hi;

  sync_gray_ff #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .clk (wr_clk),
    .rst (rst),
    .d   (rd_ptr_gray_async),
    .q   (rd_gray_sync)
  );

  always_comb begin
    fire          = wr_en & ~full_q;
    wr_ptr_bin_d  = wr_ptr_bin_q + PW'(fire);
    gray_tmp      = bin2gray(32'(wr_ptr_bin_d));
    wr_ptr_gray_d = gray_tmp[ADDR_WIDTH:0];
    bin_tmp       = gray2bin(32'(rd_gray_sync));
    rd_bin_sync   = bin_tmp[ADDR_WIDTH:0];
    // Full when next write pointer is one lap ahead of the synchronised read pointer.
    full_d        = (wr_ptr_gray_d ==
                     {~rd_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rd_gray_sync[ADDR_WIDTH-2:0]});
    wr_count_d    = wr_ptr_bin_d - rd_bin_sync;
    almost_full_d = (wr_count_d >= AFULL_LVL);
    overflow_d    = overflow_q | (wr_en & full_q);
  end

  assign unused_hi = ^{gray_tmp[31:PW], bin_tmp[31:PW]};

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      wr_ptr_bin_q  <= '0;
      wr_ptr_gray_q <= '0;
      wr_count_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_ptr_bin_q  <= wr_ptr_bin_d;
      wr_ptr_gray_q <= wr_ptr_gray_d;
      wr_count_q    <= wr_count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  assign wr_fire     = fire;
  assign wr_addr     = wr_ptr_bin_q[ADDR_WIDTH-1:0];
  assign wr_ptr_bin  = wr_ptr_bin_q;
  assign wr_ptr_gray = wr_ptr_gray_q;
  assign full        = full_q;
  assign almost_full = almost_full_q;
  assign wr_count    = wr_count_q;
  assign overflow    = overflow_q;

endmodule
